// File: rtl/fir_tdm_mac_if.sv
// Sample/coefficient/result bundle between the sample source and the shared-MAC FIR core.
// The core takes the slave modport. The source or testbench takes the master modport.
interface fir_tdm_mac_if #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int AW = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 busy;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/fir_tdm_mac.sv
// FIR filter core with one shared signed MAC. Round-half-up Q shift; FIR_SAT_EN selects clamp, otherwise wrap to DW.
// Latency: accept to out_valid is TAPS+1 cycles. Throughput is one sample per TAPS+2 cycles.
// Backpressure: in_ready is high only in IDLE. The output has no backpressure, and out_data holds between pulses.
module fir_tdm_mac #(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int TAPS  = 8,
    parameter int SHIFT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    fir_tdm_mac_if.slave  bus
);
    localparam int AW   = $clog2(TAPS);
    localparam int ACCW = DW + CW + $clog2(TAPS);
    localparam int RW   = ACCW + 1;
    localparam int RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);
    localparam logic signed [RW-1:0] RND     = (SHIFT > 0) ? (RW'(1) << RSH) : '0;
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        wp_q, wp_d;
    logic [AW-1:0]        k_q, k_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] out_dat_q, out_dat_d;
    logic                 out_vld_q, out_vld_d;
    logic signed [DW-1:0] x_q [TAPS];
    logic signed [DW-1:0] x_d [TAPS];
    logic signed [CW-1:0] h_q [TAPS];
    logic signed [CW-1:0] h_d [TAPS];

    logic [AW:0]             rd_w;
    logic [AW-1:0]           rd_idx;
    logic signed [DW+CW-1:0] prod;
    logic signed [RW-1:0]    rnd_s;
    logic signed [RW-1:0]    shf_s;
    logic signed [DW-1:0]    res;

    // Subtract modulo TAPS without a power-of-two mask so odd tap counts wrap correctly.
    always_comb begin
        if ({1'b0, wp_q} >= {1'b0, k_q})
            rd_w = {1'b0, wp_q} - {1'b0, k_q};
        else
            rd_w = {1'b0, wp_q} + (AW+1)'(TAPS) - {1'b0, k_q};
        rd_idx = rd_w[AW-1:0];
        prod   = x_q[rd_idx] * h_q[k_q];
    end

    always_comb begin
        rnd_s = {acc_q[ACCW-1], acc_q} + RND;
        shf_s = rnd_s >>> SHIFT;
`ifdef FIR_SAT_EN
        if (shf_s > SAT_MAX)
            res = SAT_MAX[DW-1:0];
        else if (shf_s < SAT_MIN)
            res = SAT_MIN[DW-1:0];
        else
            res = shf_s[DW-1:0];
`else
        res = shf_s[DW-1:0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        wp_d      = wp_q;
        k_d       = k_q;
        acc_d     = acc_q;
        out_dat_d = out_dat_q;
        out_vld_d = 1'b0;
        x_d       = x_q;
        h_d       = h_q;
        case (state_q)
            IDLE: begin
                // Coefficient write lands on the same edge as an accept, so the new tap applies to that sample.
                if (bus.coef_we && (int'(bus.coef_addr) < TAPS))
                    h_d[bus.coef_addr] = bus.coef_data;
                if (bus.in_valid) begin
                    x_d[wp_q] = bus.in_data;
                    acc_d     = '0;
                    k_d       = '0;
                    state_d   = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};
                k_d   = k_q + 1'b1;
                if (k_q == K_LAST)
                    state_d = OUT;
            end
            OUT: begin
                out_dat_d = res;
                out_vld_d = 1'b1;
                wp_d      = (wp_q == K_LAST) ? '0 : wp_q + 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wp_q      <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            out_dat_q <= '0;
            out_vld_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            out_dat_q <= out_dat_d;
            out_vld_q <= out_vld_d;
            x_q       <= x_d;
            h_q       <= h_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_dat_q;
endmodule

// File: tb/tb_fir_tdm_mac.sv
// Directed bench for fir_tdm_mac with TAPS=8 and SHIFT=0. Expected values are computed by hand.
module tb_fir_tdm_mac;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    fir_tdm_mac_if #(.DW(16), .CW(16), .AW(3)) bus ();

    fir_tdm_mac #(.DW(16), .CW(16), .TAPS(8), .SHIFT(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int k, input logic [15:0] v);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 3'(k);
        bus.coef_data = v;
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
    endtask

    // Offers one sample and waits for its result. lat counts edges from the accept edge to the out_valid cycle.
    task automatic send_sample(input logic [15:0] d, output logic [15:0] got, output int lat);
        int guard = 0;
        got = '0;
        lat = -1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && guard < 30) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 30) begin
            bus.in_valid = 1'b0;
            lat = -2;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    lat = i;
                    got = bus.out_data;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'd123;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 3'd0;
        bus.coef_data = 16'd55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 16'h0) begin n_err++; $display("FAIL rst_out_data got %h want 0000", bus.out_data); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_release_busy got %b want 0", bus.busy); end
        // A coefficient write during reset must not land, so every tap is still zero.
        begin
            logic [15:0] got;
            int lat;
            send_sample(16'd1, got, lat);
            n_cmp++; if (got !== 16'h0) begin n_err++; $display("FAIL rst_coef_ignored got %h want 0000", got); end
        end
    endtask

    task automatic test_impulse(input string tag);
        logic [15:0] got;
        int lat;
        logic [15:0] exp_y;
        for (int k = 0; k < 8; k++) write_coef(k, 16'(k + 1));
        for (int n = 0; n < 10; n++) begin
            send_sample((n == 0) ? 16'd1 : 16'd0, got, lat);
            exp_y = (n < 8) ? 16'(n + 1) : 16'd0;
            n_cmp++; if (got !== exp_y) begin n_err++; $display("FAIL %s_y[%0d] got %0d want %0d", tag, n, got, exp_y); end
            n_cmp++; if (lat != 9) begin n_err++; $display("FAIL %s_latency[%0d] got %0d want 9", tag, n, lat); end
        end
    endtask

    task automatic test_moving_sum();
        logic [15:0] ms_in [9];
        logic [15:0] ms_out [9];
        logic [15:0] got;
        int lat;
        ms_in  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd8, 16'd9, 16'd0};
        ms_out = '{16'd1, 16'd3, 16'd6, 16'd10, 16'd16, 16'd23, 16'd31, 16'd40, 16'd39};
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, 16'd1);
        for (int n = 0; n < 9; n++) begin
            send_sample(ms_in[n], got, lat);
            n_cmp++; if (got !== ms_out[n]) begin n_err++; $display("FAIL msum_y[%0d] got %0d want %0d", n, got, ms_out[n]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] acc_v, ov_v, exp_acc, exp_ov;
        do_reset();
        acc_v = '0; ov_v = '0; exp_acc = '0; exp_ov = '0;
        for (int c = 0; c < 40; c++) begin
            exp_acc[c] = (c % 10 == 0);
            exp_ov[c]  = (c % 10 == 0) && (c > 0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            acc_v[c] = bus.in_ready;
            ov_v[c]  = bus.out_valid;
        end
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        n_cmp++; if (acc_v !== exp_acc) begin n_err++; $display("FAIL b2b_accept got %h want %h", acc_v, exp_acc); end
        n_cmp++; if (ov_v !== exp_ov) begin n_err++; $display("FAIL b2b_out_valid got %h want %h", ov_v, exp_ov); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_drain_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_saturation();
        logic [15:0] got;
        int lat;
        logic [15:0] exp_pos;
        logic [15:0] exp_neg;
`ifdef FIR_SAT_EN
        exp_pos = 16'h7FFF;
`else
        exp_pos = 16'h0001;
`endif
        exp_neg = 16'h8000;
        do_reset();
        write_coef(0, 16'h7FFF);
        send_sample(16'h7FFF, got, lat);
        n_cmp++; if (got !== exp_pos) begin n_err++; $display("FAIL sat_pos got %h want %h", got, exp_pos); end
        send_sample(16'h8000, got, lat);
        n_cmp++; if (got !== exp_neg) begin n_err++; $display("FAIL sat_neg got %h want %h", got, exp_neg); end
    endtask

    task automatic test_coef_busy();
        logic [15:0] got;
        int lat;
        bit seen;
        do_reset();
        write_coef(0, 16'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd5;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 3'd0;
        bus.coef_data = 16'd100;
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
        seen = 1'b0;
        got  = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin seen = 1'b1; got = bus.out_data; end
        end
        n_cmp++; if (!seen || got !== 16'd5) begin n_err++; $display("FAIL coef_busy_y0 got %0d (seen %b) want 5", got, seen); end
        send_sample(16'd5, got, lat);
        n_cmp++; if (got !== 16'd5) begin n_err++; $display("FAIL coef_busy_y1 got %0d want 5", got); end
        // A write on the accept edge is used by that sample: 2 * 7.
        bus.coef_we   = 1'b1;
        bus.coef_addr = 3'd0;
        bus.coef_data = 16'd7;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'd2;
        @(posedge clk);
        #1;
        bus.coef_we  = 1'b0;
        bus.in_valid = 1'b0;
        seen = 1'b0;
        got  = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin seen = 1'b1; got = bus.out_data; end
        end
        n_cmp++; if (!seen || got !== 16'd14) begin n_err++; $display("FAIL coef_same_edge got %0d (seen %b) want 14", got, seen); end
    endtask

    task automatic test_reset_mid_mac();
        int ov_cnt;
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, 16'(k + 1));
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid) ov_cnt++;
        end
        n_cmp++; if (ov_cnt != 0) begin n_err++; $display("FAIL midrst_no_out_valid got %0d pulses want 0", ov_cnt); end
        n_cmp++; if (bus.out_data !== 16'h0) begin n_err++; $display("FAIL midrst_out_data got %h want 0000", bus.out_data); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
        test_impulse("midrst_imp");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        test_reset();
        do_reset();
        test_impulse("impulse");
        test_moving_sum();
        test_back_to_back();
        test_saturation();
        test_coef_busy();
        test_reset_mid_mac();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fir_tdm_mac.md
# fir_tdm_mac

Time-multiplexed, parametrised FIR filter core: one signed multiplier-accumulator is shared across all `TAPS` coefficients, so each accepted sample costs `TAPS+2` clock cycles (its cycles-per-sample figure). The core replaces the fixed two-clock (data/filter) arrangement with a single clock and a valid/ready input handshake. It adds a run-time coefficient write port and Q-format rounding. It sits between the sample source and the downstream decimator/DAC interface.

## Interface
- `DW`, 16, sample and output width (signed)
- `CW`, 16, coefficient width (signed)
- `TAPS`, 8, number of taps, ≥2
- `SHIFT`, 15, arithmetic right shift applied to the accumulator before output (Q-format), 0..DW+CW-1
- `AW` (localparam), $clog2(TAPS), coefficient/sample address width
- `ACCW` (localparam), DW+CW+$clog2(TAPS), accumulator width

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: sample offered
- `in_ready` out 1: core can accept a sample; equals (state==IDLE)
- `in_data` in DW: signed input sample
- `coef_we` in 1: coefficient write strobe
- `coef_addr` in AW: tap index k
- `coef_data` in CW: signed coefficient h[k]
- `out_valid` out 1: one-cycle pulse, `out_data` is new
- `out_data` out DW: signed filtered sample, held until next pulse
- `busy` out 1: state != IDLE

## Operation
- Storage:
  - circular sample buffer x[0..TAPS-1] with write pointer `wp`
  - coefficient register file h[0..TAPS-1]
- Reset clears all samples, coefficients, `wp`, the accumulator and `out_data` to 0.
- Outputs during and immediately after reset:
  - `out_valid`=0, `out_data`=0, `busy`=0, state=IDLE
  - `in_ready`=1, but inputs are ignored while `rst_n`=0
- States:
  - IDLE: on `in_valid && in_ready`, write `in_data` to x[wp], clear acc, set k=0, go to MAC.
  - MAC: each cycle, acc += x[(wp−k) mod TAPS] · h[k]; k increments. After k=TAPS−1, go to OUT.
  - OUT: compute `out_data` (see arithmetic below), pulse `out_valid`, wp = (wp+1) mod TAPS, go to IDLE.
- Result: y[n] = Σ h[k]·x[n−k], k=0..TAPS−1. Samples before the first accepted one count as 0.
- Arithmetic:
  - signed two's complement, full precision into `ACCW`; the accumulator never overflows
  - if SHIFT>0, add 2^(SHIFT−1) before the arithmetic shift (round half up)
  - the reduction to DW is set by the configuration macro
- Coefficient writes:
  - take effect only in IDLE; `coef_we` in MAC/OUT is ignored (no queueing)
  - `coef_we` and an accepted sample on the same IDLE edge: the write lands and the new coefficient is used for that sample
- Pointer wrap: `wp` wraps TAPS−1 → 0. The read index wraps modulo TAPS, including for non-power-of-two TAPS.
- Reset mid-MAC or mid-OUT: the computation is abandoned; no `out_valid` is produced.

## Timing
- Acceptance edge = E0. MAC occupies edges E1..E_TAPS. The OUT register loads at edge E_TAPS+1.
- `out_valid` is high for exactly the cycle following E_TAPS+1; `in_ready` is high again in that same cycle.
- Latency: input accept → `out_valid` = TAPS+1 cycles.
- Throughput: one sample per TAPS+2 cycles when `in_valid` is held high.
- `in_ready` is low for TAPS+1 cycles after each accept.
- `out_data` is registered and stable between pulses; there is no output back-pressure.

## Configuration
- `FIR_SAT_EN` defined: the shifted result is clamped to [−2^(DW−1), 2^(DW−1)−1].
- `FIR_SAT_EN` undefined: the shifted result is truncated to its low DW bits (wrap-around).

## Test plan
Bench configuration: DW=16, CW=16, TAPS=8, SHIFT=0.
1. Impulse: load h = 1..8, feed 1 followed by 9 zeros → outputs 1,2,3,4,5,6,7,8,0,0.
2. Moving sum: h[k]=1 for all k, feed 1,2,3,4,6,7,8,9,0 → 1,3,6,10,16,23,31,40,39. The last output checks the wrap of `wp`.
3. Throughput/handshake: hold `in_valid`=1 for 40 cycles.
   - accepts exactly at cycles 0,10,20,30
   - `in_ready` low for 9 cycles after each accept
   - `out_valid` 9 cycles after each accept
4. Saturation: h[0]=0x7FFF, others 0, input 0x7FFF (acc=0x3FFF0001).
   - with `FIR_SAT_EN`: `out_data`=0x7FFF
   - without: `out_data`=0x0001
   - input 0x8000 with h[0]=0x7FFF: 0x8000 saturated, 0x8000 truncated
5. Coefficient write while busy: pulse `coef_we` k=0, data=100 at MAC cycle 3 with h[0]=1 and input 5 → output 5; the next sample (5) also uses h[0]=1.
6. Reset mid-MAC: drop `rst_n` at MAC cycle 4.
   - no `out_valid`; `out_data`=0; `in_ready`=1 after release
   - the next impulse with reloaded h = 1..8 reproduces scenario 1 (buffer cleared)
